snake_game_ctrl: RTL

//   Game sequencer for the snake datapath: owns the IDLE/PLAY/OVER state, schedules snake moves
//   as one-clock move_tick pulses derived from VGA frame starts, and filters W/A/S/D presses into
//   a legal committed direction (no 180-degree reversal).

---
 rtl/snake_game_ctrl_if.sv | 29 ++
 rtl/snake_game_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/snake_game_ctrl_if.sv
// Signal bundle between the key/collision sources and the snake game sequencer.
// Handshake: every input is a one-clock qualifier with no ready/backpressure (collide may be a level);
// move_tick is a one-clock strobe that validates dir in the same cycle; other outputs are held levels.
interface snake_game_ctrl_if #(
  parameter int SCORE_W = 8
);
  logic               frame_start;
  logic               key_w;
  logic               key_a;
  logic               key_s;
  logic               key_d;
  logic               collide;
  logic               food_eaten;
  logic               move_tick;
  logic [2:0]         dir;
  logic [1:0]         game_state;
  logic [SCORE_W-1:0] score;
  logic [3:0]         level;

  modport master (
    output frame_start, key_w, key_a, key_s, key_d, collide, food_eaten,
    input  move_tick, dir, game_state, score, level
  );

  modport slave (
    input  frame_start, key_w, key_a, key_s, key_d, collide, food_eaten,
    output move_tick, dir, game_state, score, level
  );
endinterface

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: IDLE/PLAY/OVER state, frame-derived move ticks, reversal-proof
// direction filtering, saturating score and speed level.
module snake_game_ctrl #(
  parameter int TICK_BASE  = 12,
  parameter int TICK_MIN   = 3,
  parameter int LEVEL_STEP = 5,
  parameter int OVER_HOLD  = 120,
  parameter int SCORE_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  snake_game_ctrl_if.slave bus
);

  localparam int LEVEL_MAX = TICK_BASE - TICK_MIN;
  localparam int HOLD_W    = $clog2(OVER_HOLD + 1);
  localparam int STEP_W    = $clog2(LEVEL_STEP + 1);

  localparam logic [2:0] D_NONE  = 3'd0;
  localparam logic [2:0] D_UP    = 3'd1;
  localparam logic [2:0] D_LEFT  = 3'd2;
  localparam logic [2:0] D_DOWN  = 3'd3;
  localparam logic [2:0] D_RIGHT = 3'd4;
  localparam logic [2:0] D_OVER  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  state_t             state;
  logic [2:0]         dir_q;
  logic               tick_q;
  logic [SCORE_W-1:0] score_q;
  logic [3:0]         level_q;
  logic               pend_valid;
  logic [2:0]         pend_dir;
  logic [5:0]         frm_cnt;
  logic [5:0]         period_q;
  logic [STEP_W-1:0]  step_cnt;
  logic [HOLD_W-1:0]  hold_cnt;

  logic       key_any;
  logic [2:0] key_dir;
  logic [2:0] new_dir;
  logic [2:0] ref_dir;
  logic [2:0] ref_opp;
  logic [5:0] frm_next;
  logic [5:0] period_load;
  logic       tick_due;
  logic       key_legal;

  always_comb begin
    key_any = bus.key_w | bus.key_a | bus.key_s | bus.key_d;
    key_dir = D_RIGHT;
    if (bus.key_w)      key_dir = D_UP;
    else if (bus.key_a) key_dir = D_LEFT;
    else if (bus.key_s) key_dir = D_DOWN;

    new_dir     = pend_valid ? pend_dir : dir_q;
    frm_next    = frm_cnt + 6'd1;
    period_load = 6'(TICK_BASE) - {2'b00, level_q};
    tick_due    = bus.frame_start && (frm_next >= period_q);

    // On a tick cycle the pending move becomes the committed dir, so judge the key against that.
    ref_dir = tick_due ? new_dir : dir_q;
    ref_opp = D_NONE;
    case (ref_dir)
      D_UP:    ref_opp = D_DOWN;
      D_DOWN:  ref_opp = D_UP;
      D_LEFT:  ref_opp = D_RIGHT;
      D_RIGHT: ref_opp = D_LEFT;
      default: ref_opp = D_NONE;
    endcase
    key_legal = key_any && (key_dir != ref_dir) && (key_dir != ref_opp);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      dir_q      <= D_NONE;
      tick_q     <= 1'b0;
      score_q    <= '0;
      level_q    <= '0;
      pend_valid <= 1'b0;
      pend_dir   <= D_NONE;
      frm_cnt    <= '0;
      period_q   <= 6'(TICK_BASE);
      step_cnt   <= '0;
      hold_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          tick_q <= 1'b0;
          if (key_any) begin
            state      <= S_PLAY;
            dir_q      <= key_dir;
            score_q    <= '0;
            level_q    <= '0;
            pend_valid <= 1'b0;
            frm_cnt    <= '0;
            period_q   <= 6'(TICK_BASE);
            step_cnt   <= '0;
          end
        end

        S_PLAY: begin
          if (bus.collide) begin
            state      <= S_OVER;
            dir_q      <= D_OVER;
            tick_q     <= 1'b0;
            pend_valid <= 1'b0;
            hold_cnt   <= '0;
          end else begin
            tick_q <= tick_due;
            if (tick_due) begin
              frm_cnt    <= '0;
              period_q   <= period_load;
              dir_q      <= new_dir;
              pend_valid <= 1'b0;
            end else if (bus.frame_start) begin
              frm_cnt <= frm_next;
            end
            if (key_legal) begin
              pend_valid <= 1'b1;
              pend_dir   <= key_dir;
            end
            if (bus.food_eaten) begin
              if (score_q != {SCORE_W{1'b1}}) score_q <= score_q + 1'b1;
              if (step_cnt == STEP_W'(LEVEL_STEP - 1)) begin
                step_cnt <= '0;
                if (level_q < 4'(LEVEL_MAX)) level_q <= level_q + 4'd1;
              end else begin
                step_cnt <= step_cnt + 1'b1;
              end
            end
          end
        end

        S_OVER: begin
          tick_q <= 1'b0;
          if (bus.frame_start && (hold_cnt < HOLD_W'(OVER_HOLD))) hold_cnt <= hold_cnt + 1'b1;
          if (key_any && (hold_cnt == HOLD_W'(OVER_HOLD))) begin
            state <= S_IDLE;
            dir_q <= D_NONE;
          end
        end

        default: begin
          state  <= S_IDLE;
          dir_q  <= D_NONE;
          tick_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.move_tick  = tick_q;
  assign bus.dir        = dir_q;
  assign bus.game_state = state;
  assign bus.score      = score_q;
  assign bus.level      = level_q;

endmodule
